rx_id_filter: RTL

//  Parametrised receive-side frame filter on the byte stream from the Ethernet RX aligner.

---
 rtl/eth_rx_pkg.sv | 20 ++
 rtl/tagged_delay_line.sv | 37 +++
 rtl/rx_id_filter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared defaults and FSM encoding for the RX stream-ID filter.
// Imported by rx_id_filter.
package eth_rx_pkg;

    localparam int ID_OFFSET_DEF  = 34;
    localparam int SEQ_OFFSET_DEF = 35;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_IDLE,
        ST_HDR,
        ST_PASS,
        ST_DROP
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tagged_delay_line.sv
// Fixed-depth shift register carrying {en, data, tag} words.
// Ports: clk, rst_n (async clear), d_in (stage 1 input), d_out (last stage).
module tagged_delay_line #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign d_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/rx_id_filter.sv
// Forwards whole frames whose ID byte matches sel_id, with fixed latency,
// and checks a per-frame sequence byte for lost/duplicate frames.
// Ports: clk, rst (async active-low), rx_en/rx_data in, sel_id, filter_en,
// data_out/en_out delayed stream, lost/dup pulses, lost_count/dup_count.
module rx_id_filter
    import eth_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ID_OFFSET  = ID_OFFSET_DEF,
    parameter int ID_W       = 4,
    parameter int SEQ_OFFSET = SEQ_OFFSET_DEF,
    parameter int SEQ_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [ID_W-1:0]   sel_id,
    input  logic              filter_en,
    output logic [DATA_W-1:0] data_out,
    output logic              en_out,
    output logic              lost,
    output logic              dup,
    output logic [CNT_W-1:0]  lost_count,
    output logic [CNT_W-1:0]  dup_count
);

    localparam int ADDR_W = $clog2(max_int(ID_OFFSET, SEQ_OFFSET) + 2);
    localparam logic [ADDR_W-1:0] ID_A  = ADDR_W'(ID_OFFSET);
    localparam logic [ADDR_W-1:0] SEQ_A = ADDR_W'(SEQ_OFFSET);
    localparam bit SEQ_LATE = SEQ_OFFSET > ID_OFFSET;
    localparam bit SEQ_SAME = SEQ_OFFSET == ID_OFFSET;
    localparam int LW = DATA_W + 2;

    state_e             state_q, state_d;
    logic               s0_en_q, s0_en_d;
    logic [DATA_W-1:0]  s0_data_q, s0_data_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               tag_q, tag_d;
    logic [1:0]         dec_q, dec_d;
    logic               primed_q, primed_d;
    logic               synced_q, synced_d;
    logic [SEQ_W-1:0]   exp_q, exp_d;
    logic [SEQ_W-1:0]   seq_lat_q, seq_lat_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [ID_W-1:0]    frame_id_q, frame_id_d;
    logic               lost_q, lost_d;
    logic               dup_q, dup_d;
    logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;
    logic [CNT_W-1:0]   dup_cnt_q, dup_cnt_d;

    logic               cur_tag;
    logic               id_hit;
    logic               chk;
    logic [ID_W-1:0]    chk_id;
    logic [SEQ_W-1:0]   seq_val;
    logic [SEQ_W-1:0]   diff;
    logic [CNT_W:0]     lost_sum;
    logic [LW-1:0]      dl_out;
    logic               last_en;
    logic [DATA_W-1:0]  last_data;
    logic               last_tag;

    always_comb begin
        s0_en_d    = rx_en;
        s0_data_d  = rx_data;
        addr_d     = '0;
        primed_d   = 1'b1;
        state_d    = state_q;
        tag_d      = tag_q;
        dec_d      = dec_q;
        cur_tag    = tag_q;
        frame_id_d = frame_id_q;
        seq_lat_d  = seq_lat_q;
        chk        = 1'b0;
        chk_id     = frame_id_q;
        seq_val    = s0_data_q[SEQ_W-1:0];
        id_hit     = ~filter_en | (s0_data_q[ID_W-1:0] == sel_id);

        // addr follows the byte that s0 will hold next
        if (rx_en && s0_en_q) begin
            addr_d = (addr_q == '1) ? addr_q : addr_q + 1'b1;
        end

        if (s0_en_q && addr_q == SEQ_A) begin
            seq_lat_d = s0_data_q[SEQ_W-1:0];
        end

        unique case (state_q)
            // primed_q masks the s0 value cleared by reset, so a frame
            // already in flight at release is not taken as a new one
            ST_WAIT: begin
                if (primed_q && !s0_en_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (s0_en_q) begin
                    state_d        = ST_HDR;
                    tag_d          = ~tag_q;
                    cur_tag        = ~tag_q;
                    dec_d[~tag_q]  = 1'b0;
                end
            end
            ST_HDR: begin
                if (!s0_en_q) begin
                    state_d       = ST_IDLE;
                    dec_d[tag_q]  = ~filter_en;
                end else if (addr_q == ID_A) begin
                    dec_d[tag_q] = id_hit;
                    frame_id_d   = sel_id;
                    state_d      = id_hit ? ST_PASS : ST_DROP;
                    if (!SEQ_LATE && id_hit) begin
                        chk     = 1'b1;
                        chk_id  = sel_id;
                        seq_val = SEQ_SAME ? s0_data_q[SEQ_W-1:0]
                                           : seq_lat_q;
                    end
                end
            end
            ST_PASS: begin
                if (!s0_en_q) begin
                    state_d = ST_IDLE;
                end else if (SEQ_LATE && addr_q == SEQ_A) begin
                    chk = 1'b1;
                end
            end
            ST_DROP: begin
                if (!s0_en_q) state_d = ST_IDLE;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        diff       = seq_val - exp_q;
        lost_sum   = {1'b0, lost_cnt_q} + (CNT_W+1)'(diff);
        lost_d     = 1'b0;
        dup_d      = 1'b0;
        exp_d      = exp_q;
        synced_d   = synced_q;
        last_id_d  = last_id_q;
        lost_cnt_d = lost_cnt_q;
        dup_cnt_d  = dup_cnt_q;

        if (chk) begin
            last_id_d = chk_id;
            if (!synced_q || chk_id != last_id_q) begin
                synced_d = 1'b1;
                exp_d    = seq_val + 1'b1;
            end else if (diff == '0) begin
                exp_d = seq_val + 1'b1;
            end else if (diff == '1) begin
                dup_d = 1'b1;
                if (dup_cnt_q != '1) dup_cnt_d = dup_cnt_q + 1'b1;
            end else begin
                lost_d     = 1'b1;
                exp_d      = seq_val + 1'b1;
                lost_cnt_d = lost_sum[CNT_W] ? '1 : lost_sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_WAIT;
            s0_en_q    <= 1'b0;
            s0_data_q  <= '0;
            addr_q     <= '0;
            tag_q      <= 1'b0;
            dec_q      <= '0;
            primed_q   <= 1'b0;
            synced_q   <= 1'b0;
            exp_q      <= '0;
            seq_lat_q  <= '0;
            last_id_q  <= '0;
            frame_id_q <= '0;
            lost_q     <= 1'b0;
            dup_q      <= 1'b0;
            lost_cnt_q <= '0;
            dup_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            s0_en_q    <= s0_en_d;
            s0_data_q  <= s0_data_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            dec_q      <= dec_d;
            primed_q   <= primed_d;
            synced_q   <= synced_d;
            exp_q      <= exp_d;
            seq_lat_q  <= seq_lat_d;
            last_id_q  <= last_id_d;
            frame_id_q <= frame_id_d;
            lost_q     <= lost_d;
            dup_q      <= dup_d;
            lost_cnt_q <= lost_cnt_d;
            dup_cnt_q  <= dup_cnt_d;
        end
    end

    tagged_delay_line #(
        .WIDTH (LW),
        .DEPTH (ID_OFFSET + 1)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst),
        .d_in  ({s0_en_q, s0_data_q, cur_tag}),
        .d_out (dl_out)
    );

    assign {last_en, last_data, last_tag} = dl_out;

    assign en_out     = last_en & dec_q[last_tag];
    assign data_out   = last_data;
    assign lost       = lost_q;
    assign dup        = dup_q;
    assign lost_count = lost_cnt_q;
    assign dup_count  = dup_cnt_q;

endmodule
